// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer ahead of the 1024-point streaming FFT: collects real
// samples into N-point banks and launches each full bank with a minimum gap.
module fft_frame_feeder #(
  parameter int DATA_W    = 16,
  parameter int N         = 1024,
  parameter int FRAME_GAP = 5141
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              fft_next,
  output logic [DATA_W-1:0] fft_X0,
  output logic [DATA_W-1:0] fft_X1,
  output logic [DATA_W-1:0] fft_X2,
  output logic [DATA_W-1:0] fft_X3,
  output logic              streaming,
  output logic [15:0]       frames_sent
);

  localparam int HW = $clog2(N / 2);
  localparam int PW = HW + 1;
  localparam int GW = $clog2(FRAME_GAP + 1);

  localparam logic [1:0] B_EMPTY   = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_FULL    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  // Even/odd samples live in separate arrays so one read yields a full pair.
  logic [DATA_W-1:0] r_mem_even [0:N-1];
  logic [DATA_W-1:0] r_mem_odd  [0:N-1];

  logic [1:0]        r_bank_st     [0:1];
  logic [1:0]        w_bank_st_nxt [0:1];
  logic [PW-1:0]     r_wr_ptr;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [PW-1:0]     r_rd_ptr;
  logic [GW-1:0]     r_gap_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_s_ready;
  logic              r_fft_next;
  logic              r_streaming;
  logic [DATA_W-1:0] r_fft_x0;
  logic [DATA_W-1:0] r_fft_x2;
  logic [15:0]       r_frames_sent;

  logic              w_accept;
  logic              w_wr_last;
  logic              w_rd_full;
  logic              w_gap_ok;
  logic              w_done;
  logic              w_wr_bank_nxt;
  logic              w_ready_nxt;
  logic              w_launch_nxt;
  logic              w_stream_nxt;
  logic [PW-1:0]     w_wr_addr;
  logic [PW-1:0]     w_rd_addr;

  assign w_accept      = s_valid && r_s_ready;
  assign w_wr_last     = w_accept && (r_wr_ptr == PW'(N - 1));
  // A bank completing this cycle counts as full so launch follows immediately.
  assign w_rd_full     = (r_bank_st[r_rd_bank] == B_FULL) ||
                         (w_wr_last && (r_wr_bank == r_rd_bank));
  assign w_gap_ok      = (r_gap_cnt >= GW'(FRAME_GAP - 1));
  assign w_done        = (r_state == S_STREAM) && (r_rd_ptr == PW'(N / 2));
  assign w_wr_bank_nxt = w_wr_last ? ~r_wr_bank : r_wr_bank;
  assign w_wr_addr     = {r_wr_bank, r_wr_ptr[PW-1:1]};
  assign w_rd_addr     = {r_rd_bank, r_rd_ptr[HW-1:0]};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (w_accept && (r_wr_bank == 1'(b))) begin
        w_bank_st_nxt[b] = w_wr_last ? B_FULL : B_FILLING;
      end else if (w_done && (r_rd_bank == 1'(b))) begin
        w_bank_st_nxt[b] = B_EMPTY;
      end else begin
        w_bank_st_nxt[b] = r_bank_st[b];
      end
    end
  end

  assign w_ready_nxt = (w_bank_st_nxt[w_wr_bank_nxt] != B_FULL);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_full && w_gap_ok) begin
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_launch_nxt = (w_state_nxt == S_LAUNCH);
    w_stream_nxt = (w_state_nxt == S_STREAM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_wr_ptr[0]) begin
        r_mem_odd[w_wr_addr] <= s_data;
      end else begin
        r_mem_even[w_wr_addr] <= s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_wr_bank    <= 1'b0;
      r_bank_st[0] <= B_EMPTY;
      r_bank_st[1] <= B_EMPTY;
      r_s_ready    <= 1'b0;
    end else begin
      r_wr_ptr     <= w_accept ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
      r_wr_bank    <= w_wr_bank_nxt;
      r_bank_st[0] <= w_bank_st_nxt[0];
      r_bank_st[1] <= w_bank_st_nxt[1];
      r_s_ready    <= w_ready_nxt;
    end
  end

  // The pair for the next stream cycle is read one cycle ahead into the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bank     <= 1'b0;
      r_rd_ptr      <= '0;
      r_gap_cnt     <= GW'(FRAME_GAP - 1);
      r_fft_next    <= 1'b0;
      r_streaming   <= 1'b0;
      r_fft_x0      <= '0;
      r_fft_x2      <= '0;
      r_frames_sent <= 16'd0;
    end else begin
      r_rd_bank     <= w_done ? ~r_rd_bank : r_rd_bank;
      if (w_launch_nxt) begin
        r_rd_ptr <= '0;
      end else if (w_stream_nxt) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (w_launch_nxt) begin
        r_gap_cnt <= '0;
      end else if (!w_gap_ok) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= r_gap_cnt;
      end
      r_fft_next    <= w_launch_nxt;
      r_streaming   <= w_stream_nxt;
      r_fft_x0      <= w_stream_nxt ? r_mem_even[w_rd_addr] : '0;
      r_fft_x2      <= w_stream_nxt ? r_mem_odd[w_rd_addr] : '0;
      r_frames_sent <= r_frames_sent + {15'd0, w_done};
    end
  end

  assign s_ready     = r_s_ready;
  assign fft_next    = r_fft_next;
  assign streaming   = r_streaming;
  assign fft_X0      = r_fft_x0;
  assign fft_X1      = '0;
  assign fft_X2      = r_fft_x2;
  assign fft_X3      = '0;
  assign frames_sent = r_frames_sent;

endmodule
